// File: rtl/lifo_serializer.sv
// Drains the project LIFO one word at a time and shifts each word out LSB first
// on a valid/ready serial link, with an optional even-parity bit per frame.
module lifo_serializer #(
  parameter int unsigned DATA_W    = 5,
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lifo_val,
  input  logic [DATA_W-1:0] lifo_data,
  output logic              lifo_read,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BC_W-1:0]   bitcnt_q;
  logic              parity_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_bit;

  assign last_bit = (bitcnt_q == BC_W'(DATA_W - 1));

  // State, datapath and frame counter; reset wins over everything, even mid-frame
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lifo_val) begin
            shift_q  <= lifo_data;
            bitcnt_q <= '0;
            parity_q <= ^lifo_data;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            shift_q  <= shift_q >> 1;
            bitcnt_q <= bitcnt_q + BC_W'(1);
            if (last_bit) begin
              if (PARITY_EN) begin
                state_q <= PAR;
              end else begin
                state_q <= GAP;
                cnt_q   <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        PAR: begin
          if (ser_ready) begin
            state_q <= GAP;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Link outputs are a decode of the current state, forced quiet while in reset
  always_comb begin
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    if (reset) begin
      unique case (state_q)
        SHIFT: begin
          ser_valid = 1'b1;
          ser_data  = shift_q[0];
          ser_first = (bitcnt_q == '0);
          ser_last  = last_bit && !PARITY_EN;
        end
        PAR: begin
          ser_valid = 1'b1;
          ser_data  = parity_q;
          ser_last  = 1'b1;
        end
        default: ser_valid = 1'b0;
      endcase
    end
  end

  assign lifo_read  = (state_q == IDLE) && lifo_val && reset;
  assign busy       = (state_q != IDLE) && reset;
  assign words_sent = cnt_q;

endmodule
